// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store unit between a CPU pipeline and a word-organised,
//            combinationally-read data memory. Loads and word stores finish
//            in the request cycle. Byte/halfword stores use a two-cycle
//            read-modify-write: the request cycle reads and merges, and the
//            following WRITE cycle writes the merged word back.
// Option   : MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//            accesses raise Misaligned and are suppressed. When undefined,
//            the offending low address bits are ignored.
// Ports    : clk, reset (async, active high)
//            MemRead, MemWrite, Size[1:0], Unsigned, Address, WriteData
//                                   - pipeline request
//            ReadData, Stall, Misaligned
//                                   - pipeline response
//            MemAddress (word index), MemWriteData, MemWe, MemRe
//                                   - memory side outputs
//            MemReadData            - combinational memory read data
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 1024,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  input  logic [DATA_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  Misaligned,
  output logic [DATA_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemWe,
  output logic                  MemRe,
  input  logic [DATA_WIDTH-1:0] MemReadData
);

  localparam int c_IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] c_IDX_MASK =
    {{(DATA_WIDTH-c_IDX_W){1'b0}}, {c_IDX_W{1'b1}}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [DATA_WIDTH-1:0] r_merged;
  logic [DATA_WIDTH-1:0] r_wordIdx;
  logic                  w_loadMerged;

  logic [DATA_WIDTH-1:0] w_offset;
  logic [DATA_WIDTH-1:0] w_wordIdx;
  logic [1:0]            w_byteLane;
  logic                  w_halfLane;
  logic [7:0]            w_loadByte;
  logic [15:0]           w_loadHalf;
  logic [DATA_WIDTH-1:0] w_loadExt;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_request;
  logic                  w_misalignedAddr;

  // Word index relative to the memory base. Masking (instead of slicing)
  // keeps every offset bit in use; addresses outside the window wrap.
  assign w_offset   = Address - BASE_ADDR;
  assign w_wordIdx  = (w_offset >> 2) & c_IDX_MASK;

  // Little-endian lane selection.
  assign w_byteLane = Address[1:0];
  assign w_halfLane = Address[1];
  assign w_loadByte = MemReadData[{w_byteLane, 3'b000} +: 8];
  assign w_loadHalf = MemReadData[{w_halfLane, 4'b0000} +: 16];
  assign w_request  = MemRead | MemWrite;

`ifdef MISALIGN_TRAP_EN
  assign w_misalignedAddr = (Size == 2'b01) ? Address[0]
                          : (Size[1] ? (Address[1:0] != 2'b00) : 1'b0);
`else
  assign w_misalignedAddr = 1'b0;
`endif

  // Load result extension; Size 11 behaves as a word.
  always_comb begin
    w_loadExt = MemReadData;
    case (Size)
      2'b00:   w_loadExt = {{(DATA_WIDTH-8){~Unsigned & w_loadByte[7]}}, w_loadByte};
      2'b01:   w_loadExt = {{(DATA_WIDTH-16){~Unsigned & w_loadHalf[15]}}, w_loadHalf};
      default: w_loadExt = MemReadData;
    endcase
  end

  // Read-modify-write merge: current memory word with the target lane
  // replaced by the low bits of the store data.
  always_comb begin
    w_merged = MemReadData;
    if (Size == 2'b00) begin
      w_merged[{w_byteLane, 3'b000} +: 8] = WriteData[7:0];
    end else begin
      w_merged[{w_halfLane, 4'b0000} +: 16] = WriteData[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_merged  <= '0;
      r_wordIdx <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_loadMerged) begin
        r_merged  <= w_merged;
        r_wordIdx <= w_wordIdx;
      end
    end
  end

  // Outputs are gated by reset so they clear immediately, not at the
  // next edge. The WRITE cycle uses the index captured with the merged
  // word, so request inputs are fully ignored there.
  always_comb begin
    w_nextState  = r_state;
    w_loadMerged = 1'b0;
    MemRe        = 1'b0;
    MemWe        = 1'b0;
    Stall        = 1'b0;
    Misaligned   = 1'b0;
    ReadData     = '0;
    MemWriteData = WriteData;
    MemAddress   = w_wordIdx;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_request && w_misalignedAddr) begin
            Misaligned = 1'b1;
          end else if (MemWrite) begin
            // Stores take priority over a simultaneous load.
            if (Size[1]) begin
              MemWe = 1'b1;
            end else begin
              MemRe        = 1'b1;
              Stall        = 1'b1;
              w_loadMerged = 1'b1;
              w_nextState  = WRITE;
            end
          end else if (MemRead) begin
            MemRe    = 1'b1;
            ReadData = w_loadExt;
          end
        end
        WRITE: begin
          MemWe        = 1'b1;
          MemWriteData = r_merged;
          MemAddress   = r_wordIdx;
          w_nextState  = IDLE;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
